// File: rtl/seq_div4_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings
// and the default operand width.
package seq_div4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div4_sub_ripple.sv
// Combinational ripple borrow-chain subtractor: d = a - b - bin, with the
// final borrow out of the top bit on bout.
module sub_ripple
    import seq_div4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign d[i]          = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[WIDTH];

endmodule

// File: rtl/seq_div4.sv
// Sequential restoring divider: one quotient bit per clock via shift and
// trial subtraction, with quotient/remainder returned on a one-cycle done pulse.
module seq_div4
    import seq_div4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvsr;
    logic             zero_pend;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             bout;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // The stored partial remainder is always below the divisor, so it fits in
    // WIDTH bits; the shifted trial value needs the extra top bit.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        borrow   = bout | diff[WIDTH];
        rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], ~borrow};
    end

    sub_ripple #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a   (shifted),
        .b   ({1'b0, dvsr}),
        .bin (1'b0),
        .d   (diff),
        .bout(bout)
    );

    // Divide-by-zero still spends one CALC cycle, so its done pulse follows
    // the second edge after start; the dividend rides along in quo_reg.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvsr        <= '0;
            zero_pend   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvsr      <= divisor;
                        rem_reg   <= '0;
                        quo_reg   <= dividend;
                        count     <= '0;
                        zero_pend <= (divisor == '0);
                        busy      <= 1'b1;
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (zero_pend) begin
                        quotient    <= '1;
                        remainder   <= quo_reg;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        count   <= count + 1'b1;
                        if (count == LAST_ITER) begin
                            quotient    <= quo_next;
                            remainder   <= rem_next;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div4.sv
// Directed and sweep bench for seq_div4: latency, results, divide-by-zero,
// start-while-busy, mid-division reset and result hold behaviour.
module tb_seq_div4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int assert_count = 0;
    int fail_count   = 0;

    logic [3:0] last_q = 4'd0;
    logic [3:0] last_r = 4'd0;
    logic       last_z = 1'b0;

    seq_div4 #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issue one division and follow it through to the cycle after done.
    task automatic applyStimulus(input logic [3:0] n, input logic [3:0] d,
                                 input logic [3:0] eq, input logic [3:0] er,
                                 input logic ez, input int elat, input string tag);
        int cycles;
        @(negedge clk);
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        checkOutput({tag, "_busy"}, busy, 1);
        while (done !== 1'b1 && cycles < 20) begin
            checkOutput({tag, "_hold_q"}, quotient, last_q);
            checkOutput({tag, "_hold_r"}, remainder, last_r);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, elat);
        checkOutput({tag, "_q"}, quotient, eq);
        checkOutput({tag, "_r"}, remainder, er);
        checkOutput({tag, "_dbz"}, div_by_zero, ez);
        checkOutput({tag, "_busy_done"}, busy, 1);
        last_q = eq;
        last_r = er;
        last_z = ez;
        @(negedge clk);
        checkOutput({tag, "_done_once"}, done, 0);
        checkOutput({tag, "_idle"}, busy, 0);
        checkOutput({tag, "_keep_q"}, quotient, eq);
    endtask

    initial begin
        int cycles;
        int pulses;
        logic [3:0] eq;
        logic [3:0] er;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_q", quotient, 0);
        checkOutput("rst_r", remainder, 0);
        checkOutput("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        $display("[TB] basic and boundary operands");
        applyStimulus(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "d13_3");
        applyStimulus(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, "d15_1");
        applyStimulus(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 5, "d3_7");
        applyStimulus(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5, "d0_5");
        applyStimulus(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, "d15_15");

        $display("[TB] divide by zero");
        applyStimulus(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 2, "d9_0");
        applyStimulus(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5, "d8_2");

        $display("[TB] start held while busy");
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(negedge clk);
        dividend = 4'd1;
        divisor  = 4'd1;
        cycles   = 1;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_latency", cycles, 5);
        checkOutput("b2b_q", quotient, 3);
        checkOutput("b2b_r", remainder, 2);
        @(negedge clk);
        checkOutput("b2b_idle_busy", busy, 0);
        checkOutput("b2b_idle_done", done, 0);
        @(negedge clk);
        checkOutput("b2b_accept", busy, 1);
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b2_latency", cycles, 5);
        checkOutput("b2b2_q", quotient, 1);
        checkOutput("b2b2_r", remainder, 0);
        @(negedge clk);
        checkOutput("b2b2_done_once", done, 0);
        last_q = 4'd1;
        last_r = 4'd0;
        last_z = 1'b0;

        $display("[TB] reset during division");
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_q", quotient, 0);
        checkOutput("abort_r", remainder, 0);
        checkOutput("abort_dbz", div_by_zero, 0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);
        last_q = 4'd0;
        last_r = 4'd0;
        last_z = 1'b0;
        applyStimulus(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5, "d12_5");

        $display("[TB] exhaustive sweep");
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                if (d == 0) begin
                    applyStimulus(4'(n), 4'(d), 4'd15, 4'(n), 1'b1, 2, "sweep");
                end else begin
                    eq = 4'(n / d);
                    er = 4'(n % d);
                    applyStimulus(4'(n), 4'(d), eq, er, 1'b0, 5, "sweep");
                    checkOutput("sweep_identity", quotient * d + remainder, n);
                    checkOutput("sweep_rem_lt", (remainder < d) ? 1 : 0, 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
